error_detect_sampler: RTL and testbench

//  Timing-error detection stage directly upstream of token_controller.
//  On each controller `sample` request it latches stage data twice:
//   - main copy at sample rise;
//   - shadow copy SHADOW_DELAY clocks later.
//  It compares the two and answers on dual-rail Err0 (no error) / Err1 (error),

---
 rtl/error_detect_sampler.sv | 173 +++++++++++++++++
 tb/tb_error_detect_sampler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/error_detect_sampler.sv
// error_detect_sampler
//   Timing-error detection stage that sits in front of token_controller.
//   For each sample request it latches data_in twice. The main copy is taken
//   on the sample rise. The shadow copy is taken SHADOW_DELAY clocks later.
//   The two copies are compared, and the result is answered on a
//   return-to-zero dual-rail pair: Err0 means no error, Err1 means error.
//   When there is an error, the shadow (late, correct) value is forwarded.
//
// Parameters
//   WIDTH         data path width
//   SHADOW_DELAY  clocks between main and shadow capture (>= 1)
//   CNT_WIDTH     width of the saturating error counter
//
// Ports
//   clk        in   clock, all state updates on posedge
//   rst        in   synchronous reset, active-high
//   sample     in   sample request (level, return-to-zero)
//   data_in    in   stage data to be checked
//   clr_count  in   synchronous clear of err_count and proto_err
//   Err0       out  no-error rail (registered)
//   Err1       out  error rail (registered)
//   data_out   out  main value, or shadow value after an error
//   err_count  out  number of Err1 responses, saturating
//   proto_err  out  sticky flag: sample dropped before a rail was issued
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a sample rise; main copy taken on the rise
// ST_WAIT  | counting clocks until the shadow capture edge
// ST_EVAL  | comparing main and shadow, then issuing a rail (or proto_err)
// ST_HOLD  | rail held until sample returns low

module error_detect_sampler #(
    parameter int WIDTH        = 8,
    parameter int SHADOW_DELAY = 2,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 clr_count,
    output logic                 Err0,
    output logic                 Err1,
    output logic [WIDTH-1:0]     data_out,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 proto_err
);

    localparam int CW = (SHADOW_DELAY < 1) ? 1 : $clog2(SHADOW_DELAY + 1);
    localparam logic [CW-1:0]        SHADOW_CNT = CW'(SHADOW_DELAY);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EVAL = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 sample_q;
    logic                 rise;
    logic [WIDTH-1:0]     main_q, main_d;
    logic [WIDTH-1:0]     shadow_q, shadow_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err0_d, err1_d;
    logic [WIDTH-1:0]     data_d;
    logic [CNT_WIDTH-1:0] err_count_d;
    logic                 proto_d;
    logic                 count_inc;
    logic                 proto_set;

    assign rise = sample & ~sample_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sample_q  <= 1'b0;
            main_q    <= '0;
            shadow_q  <= '0;
            cnt_q     <= '0;
            Err0      <= 1'b0;
            Err1      <= 1'b0;
            data_out  <= '0;
            err_count <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample;
            main_q    <= main_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            Err0      <= err0_d;
            Err1      <= err1_d;
            data_out  <= data_d;
            err_count <= err_count_d;
            proto_err <= proto_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        err0_d    = Err0;
        err1_d    = Err1;
        data_d    = data_out;
        count_inc = 1'b0;
        proto_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    main_d  = data_in;
                    cnt_d   = CW'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // cnt holds the number of edges since the rise, so the shadow
                // capture happens on the edge where it equals SHADOW_DELAY
                if (cnt_q == SHADOW_CNT) begin
                    shadow_d = data_in;
                    state_d  = ST_EVAL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_EVAL: begin
                if (sample) begin
                    if (main_q == shadow_q) begin
                        err0_d = 1'b1;
                        data_d = main_q;
                    end else begin
                        err1_d    = 1'b1;
                        data_d    = shadow_q;
                        count_inc = 1'b1;
                    end
                    state_d = ST_HOLD;
                end else begin
                    // requester gave up before the answer: flag it, no rail
                    proto_set = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!sample) begin
                    err0_d  = 1'b0;
                    err1_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A clear that coincides with an Err1 issue still counts that error.
    always_comb begin
        err_count_d = err_count;
        if (clr_count) begin
            err_count_d = count_inc ? CNT_WIDTH'(1) : '0;
        end else if (count_inc && (err_count != CNT_MAX)) begin
            err_count_d = err_count + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        proto_d = clr_count ? proto_set : (proto_err | proto_set);
    end

endmodule

// File: tb/tb_error_detect_sampler.sv
module tb_error_detect_sampler;

    logic       clk;
    logic       rst;
    logic       sample;
    logic [7:0] data_in;
    logic       clr_count;

    logic       err0_a, err1_a, proto_a;
    logic [7:0] data_a;
    logic [7:0] cnt_a;

    logic       err0_b, err1_b, proto_b;
    logic [7:0] data_b;
    logic [1:0] cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    int exp_c8    = 0;
    int exp_c2    = 0;
    int exp_proto = 0;

    error_detect_sampler #(.WIDTH(8), .SHADOW_DELAY(2), .CNT_WIDTH(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sample    (sample),
        .data_in   (data_in),
        .clr_count (clr_count),
        .Err0      (err0_a),
        .Err1      (err1_a),
        .data_out  (data_a),
        .err_count (cnt_a),
        .proto_err (proto_a)
    );

    error_detect_sampler #(.WIDTH(8), .SHADOW_DELAY(2), .CNT_WIDTH(2)) u_dut_sat (
        .clk       (clk),
        .rst       (rst),
        .sample    (sample),
        .data_in   (data_in),
        .clr_count (clr_count),
        .Err0      (err0_b),
        .Err1      (err1_b),
        .data_out  (data_b),
        .err_count (cnt_b),
        .proto_err (proto_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] main_val;
        logic [7:0] shadow_val;
        logic       exp_err1;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_err_count"}, 32'(cnt_a), 32'(exp_c8));
        chk({tag, "_err_count_sat"}, 32'(cnt_b), 32'(exp_c2));
        chk({tag, "_proto_err"}, 32'(proto_a), 32'(exp_proto));
    endtask

    // One sample pulse: main value on the rise edge T0, shadow value at T0+2,
    // rail expected after T0+3. clr drives clr_count on the T0+3 edge.
    task automatic pulse(input string tag, input logic [7:0] m, input logic [7:0] s,
                         input logic e1, input logic [7:0] d, input logic clr,
                         input logic keep_high);
        data_in = m;
        sample  = 1'b1;
        step();                       // T0
        step();                       // T0+1
        data_in = s;
        step();                       // T0+2
        chk({tag, "_early_rails"}, 32'({err0_a, err1_a}), 32'(0));
        clr_count = clr;
        step();                       // T0+3
        clr_count = 1'b0;
        if (clr) begin
            exp_c8    = e1 ? 1 : 0;
            exp_c2    = e1 ? 1 : 0;
            exp_proto = 0;
        end else if (e1) begin
            exp_c8 = (exp_c8 == 255) ? 255 : exp_c8 + 1;
            exp_c2 = (exp_c2 == 3) ? 3 : exp_c2 + 1;
        end
        chk({tag, "_Err0"}, 32'(err0_a), 32'(!e1));
        chk({tag, "_Err1"}, 32'(err1_a), 32'(e1));
        chk({tag, "_data_out"}, 32'(data_a), 32'(d));
        check_counts(tag);
        if (!keep_high) begin
            sample = 1'b0;
            step();                   // T0+4
            chk({tag, "_rails_rtz"}, 32'({err0_a, err1_a}), 32'(0));
            chk({tag, "_data_hold"}, 32'(data_a), 32'(d));
            step();
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 8'h3D, 1'b1, 8'h3D};
        vecs[2] = '{8'h00, 8'hFF, 1'b1, 8'hFF};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'hFF};
        vecs[4] = '{8'h5A, 8'h5B, 1'b1, 8'h5B};
        vecs[5] = '{8'h80, 8'h00, 1'b1, 8'h00};

        rst       = 1'b1;
        sample    = 1'b0;
        data_in   = 8'h00;
        clr_count = 1'b0;
        step();
        step();
        step();
        chk("reset_rails", 32'({err0_a, err1_a}), 32'(0));
        chk("reset_data_out", 32'(data_a), 32'(0));
        check_counts("reset");
        rst = 1'b0;
        step();
        chk("post_reset_rails", 32'({err0_a, err1_a}), 32'(0));

        // table: 4 mismatches, saturates the 2-bit counter at 3
        for (int i = 0; i < 6; i++) begin
            pulse($sformatf("vec%0d", i), vecs[i].main_val, vecs[i].shadow_val,
                  vecs[i].exp_err1, vecs[i].exp_data, 1'b0, 1'b0);
        end

        // sample dropped while waiting for the shadow capture
        data_in = 8'h44;
        sample  = 1'b1;
        step();                       // T0
        step();                       // T0+1
        sample = 1'b0;
        step();                       // T0+2
        step();                       // T0+3
        exp_proto = 1;
        chk("short_pulse_rails", 32'({err0_a, err1_a}), 32'(0));
        chk("short_pulse_proto", 32'(proto_a), 32'(1));
        step();
        chk("short_pulse_rails_late", 32'({err0_a, err1_a}), 32'(0));
        pulse("after_short", 8'h12, 8'h12, 1'b0, 8'h12, 1'b0, 1'b0);

        // fifth mismatch keeps saturated counter at 3
        pulse("err5", 8'h01, 8'h02, 1'b1, 8'h02, 1'b0, 1'b0);
        chk("sat_value", 32'(cnt_b), 32'(3));
        // clear coincident with sixth error
        pulse("clr_err6", 8'h70, 8'h71, 1'b1, 8'h71, 1'b1, 1'b0);

        // reset while holding Err1
        pulse("hold_err", 8'h11, 8'h22, 1'b1, 8'h22, 1'b0, 1'b1);
        rst    = 1'b1;
        sample = 1'b0;
        step();
        exp_c8    = 0;
        exp_c2    = 0;
        exp_proto = 0;
        chk("rst_in_hold_Err1", 32'(err1_a), 32'(0));
        chk("rst_in_hold_data", 32'(data_a), 32'(0));
        check_counts("rst_in_hold");
        rst = 1'b0;
        step();
        pulse("after_rst", 8'hC3, 8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0);

        // random activity: rails must stay mutually exclusive
        for (int i = 0; i < 400; i++) begin
            sample  = ($urandom_range(0, 3) != 0);
            data_in = 8'($urandom);
            step();
            chk("rails_exclusive", 32'(err0_a & err1_a), 32'(0));
            chk("rails_exclusive_sat", 32'(err0_b & err1_b), 32'(0));
        end
        sample = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
